// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      ST_LEN  = 3'd0,
      ST_DATA = 3'd1,
      ST_CSUM = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } loader_state_e;

   // Field sizes in bytes
   localparam int LEN_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   // Little-endian byte lanes: lane k holds bits [8k+7:8k]
   localparam int LANE_B0 = 0;
   localparam int LANE_B1 = 1;
   localparam int LANE_B2 = 2;
   localparam int LANE_B3 = 3;

   // Pack four bytes, first-received byte in the least significant lane
   function automatic logic [31:0] pack_le(input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2,
                                           input logic [7:0] b3);
      logic [31:0] w;
      w = 32'h0000_0000;
      w[8*LANE_B0 +: 8] = b0;
      w[8*LANE_B1 +: 8] = b1;
      w[8*LANE_B2 +: 8] = b2;
      w[8*LANE_B3 +: 8] = b3;
      return w;
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects a little-endian byte stream into 32-bit words. The first three
// bytes are held in lane registers; the fourth is taken straight from the
// input so the finished word and its word_valid pulse appear in the same
// cycle as the accepting edge.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

   logic [1:0] idx_q, idx_d;
   logic [7:0] lane0_q, lane0_d;
   logic [7:0] lane1_q, lane1_d;
   logic [7:0] lane2_q, lane2_d;

   // Next byte index (wraps 3->0) and lane capture for the held bytes
   always_comb begin
      idx_d   = idx_q;
      lane0_d = lane0_q;
      lane1_d = lane1_q;
      lane2_d = lane2_q;
      if (clear_i) begin
         idx_d = 2'd0;
      end else if (byte_valid_i) begin
         idx_d = idx_q + 2'd1;
         case (idx_q)
            2'(LANE_B0): lane0_d = byte_i;
            2'(LANE_B1): lane1_d = byte_i;
            2'(LANE_B2): lane2_d = byte_i;
            default:     lane0_d = lane0_q;
         endcase
      end else begin
         idx_d = idx_q;
      end
   end

   assign word_valid_o = byte_valid_i && (idx_q == LAST_IDX);
   assign word_o       = pack_le(lane0_q, lane1_q, lane2_q, byte_i);

   // Index and lane registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx_q   <= 2'd0;
         lane0_q <= 8'h00;
         lane1_q <= 8'h00;
         lane2_q <= 8'h00;
      end else begin
         idx_q   <= idx_d;
         lane0_q <= lane0_d;
         lane1_q <= lane1_d;
         lane2_q <= lane2_d;
      end
   end

endmodule

// File: rtl/imem_program_loader.sv
// Program-image loader: byte stream in, 32-bit instruction-memory writes out.
// Holds the core in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte check (CSUM state). Without it the loader goes to DONE right after
// the last word.
module imem_program_loader
   import loader_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        reload,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

   localparam int          IDXW      = $clog2(DEPTH_WORDS) + 1;
   localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);
`ifdef LOADER_CHECKSUM_EN
   localparam loader_state_e ST_AFTER = ST_CSUM;
`else
   localparam loader_state_e ST_AFTER = ST_DONE;
`endif

   loader_state_e   state_q, state_d;
   logic [IDXW-1:0] cnt_q, cnt_d;
   logic [IDXW-1:0] len_q, len_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif
   logic            rx_ready_q, rx_ready_d;
   logic            we_q, we_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            hold_q, hold_d;
   logic            done_q, done_d;
   logic            error_q, error_d;

   logic            accept_s;
   logic            asm_clear_s;
   logic [31:0]     word_s;
   logic            word_valid_s;
   logic            last_word_s;

   assign accept_s    = rx_valid && rx_ready_q;
   assign last_word_s = (cnt_q == (len_q - IDXW'(1)));

   word_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (asm_clear_s),
      .byte_valid_i (accept_s),
      .byte_i       (rx_data),
      .word_o       (word_s),
      .word_valid_o (word_valid_s)
   );

   // Next-state logic: FSM transitions, word counter, length and checksum
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      asm_clear_s = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         ST_LEN: begin
            if (accept_s && word_valid_s) begin
               cnt_d = '0;
               len_d = word_s[IDXW-1:0];
               if (word_s > DEPTH_W32) begin
                  state_d = ST_ERR;
               end else if (word_s == 32'h0000_0000) begin
                  state_d = ST_AFTER;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               if (word_valid_s) begin
                  cnt_d = cnt_q + IDXW'(1);
                  if (last_word_s) begin
                     state_d = ST_AFTER;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept_s) begin
               if (rx_data == csum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
               end
            end else begin
               state_d = ST_CSUM;
            end
         end
`endif
         ST_DONE: begin
            if (reload) begin
               state_d     = ST_LEN;
               cnt_d       = '0;
               len_d       = '0;
               asm_clear_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               csum_d      = 8'h00;
`endif
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_ERR;
         end
      endcase
   end

   // Output next values: write register loads on each completed data word,
   // status flags follow the next state so they change with the transition
   always_comb begin
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if ((state_q == ST_DATA) && accept_s && word_valid_s) begin
         we_d    = 1'b1;
         addr_d  = BASE_ADDR + (32'(cnt_q) * 32'(WORD_BYTES));
         wdata_d = word_s;
      end else begin
         we_d = 1'b0;
      end
      case (state_d)
         ST_LEN, ST_DATA, ST_CSUM: begin
            rx_ready_d = 1'b1;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b0;
         end
         ST_DONE: begin
            rx_ready_d = 1'b0;
            hold_d     = 1'b0;
            done_d     = 1'b1;
            error_d    = 1'b0;
         end
         default: begin
            rx_ready_d = 1'b0;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            error_d    = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_LEN;
         cnt_q      <= '0;
         len_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= 8'h00;
`endif
         rx_ready_q <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= 32'h0000_0000;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
         rx_ready_q <= rx_ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign core_hold  = hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader. Expected memory writes are
// queued as bytes are driven and popped by a write monitor.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_program_loader;

   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        reload;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        done;
   logic        error;

   int          n_cmp;
   int          n_err;
   int          wr_cnt;
   logic [63:0] exp_q[$];

   imem_program_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      reload   = 1'b0;
      reset    = 1'b0;
      tick();
      reset    = 1'b1;
      exp_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int guard;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      rx_data  = b;
      rx_valid = 1'b1;
      guard    = 0;
      while (rx_ready !== 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout rx_ready=%b after %0d cycles, required 1", rx_ready, guard);
      end else begin
         tick();
      end
      rx_valid = 1'b0;
   endtask

   task automatic monitor_writes();
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (imem_we !== 1'b0) begin
            wr_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_write got addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
               e = exp_q.pop_front();
               if ({imem_addr, imem_wdata} !== e) begin
                  n_err++;
                  $display("FAIL write got addr=%h data=%h, required addr=%h data=%h",
                           imem_addr, imem_wdata, e[63:32], e[31:0]);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      reset = 1'b1;
      n_cmp += 7;
      if (rx_ready !== 1'b1)    begin n_err++; $display("FAIL reset_rx_ready got %b required 1", rx_ready); end
      if (imem_we !== 1'b0)     begin n_err++; $display("FAIL reset_we got %b required 0", imem_we); end
      if (imem_addr !== BASE)   begin n_err++; $display("FAIL reset_addr got %h required %h", imem_addr, BASE); end
      if (imem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h required 0", imem_wdata); end
      if (core_hold !== 1'b1)   begin n_err++; $display("FAIL reset_hold got %b required 1", core_hold); end
      if (done !== 1'b0)        begin n_err++; $display("FAIL reset_done got %b required 0", done); end
      if (error !== 1'b0)       begin n_err++; $display("FAIL reset_error got %b required 0", error); end
   endtask

   task automatic test_normal_load();
      logic [7:0] s[$];
      int w0;
      s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef LOADER_CHECKSUM_EN
      s.push_back(8'h44);
`endif
      do_reset();
      w0 = wr_cnt;
      exp_q.push_back({BASE, 32'h1122_3344});
      exp_q.push_back({BASE + 32'd4, 32'hAABB_CCDD});
      for (int i = 0; i < s.size(); i++) begin
         send_byte(s[i], 0);
         if (i == 6) begin
            n_cmp++;
            if (imem_we !== 1'b0) begin n_err++; $display("FAIL early_we got %b required 0", imem_we); end
         end
         if (i == 7) begin
            n_cmp += 2;
            if (imem_we !== 1'b1) begin n_err++; $display("FAIL we_latency got %b required 1", imem_we); end
            if (core_hold !== 1'b1) begin n_err++; $display("FAIL hold_during_data got %b required 1", core_hold); end
         end
      end
      n_cmp += 4;
      if (done !== 1'b1)      begin n_err++; $display("FAIL normal_done got %b required 1", done); end
      if (core_hold !== 1'b0) begin n_err++; $display("FAIL normal_hold got %b required 0", core_hold); end
      if (rx_ready !== 1'b0)  begin n_err++; $display("FAIL normal_rx_ready got %b required 0", rx_ready); end
      if (error !== 1'b0)     begin n_err++; $display("FAIL normal_error got %b required 0", error); end
      repeat (2) tick();
      n_cmp += 2;
      if (wr_cnt - w0 != 2)   begin n_err++; $display("FAIL normal_writes got %0d required 2", wr_cnt - w0); end
      if (exp_q.size() != 0)  begin n_err++; $display("FAIL normal_pending got %0d required 0", exp_q.size()); end
   endtask

   task automatic test_reload_gaps();
      logic [7:0] s[$];
      int w0;
      s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
      s.push_back(8'h08);
`endif
      reload = 1'b1;
      tick();
      reload = 1'b0;
      n_cmp += 3;
      if (core_hold !== 1'b1) begin n_err++; $display("FAIL reload_hold got %b required 1", core_hold); end
      if (done !== 1'b0)      begin n_err++; $display("FAIL reload_done got %b required 0", done); end
      if (rx_ready !== 1'b1)  begin n_err++; $display("FAIL reload_rx_ready got %b required 1", rx_ready); end
      w0 = wr_cnt;
      exp_q.push_back({BASE, 32'h1234_5678});
      for (int i = 0; i < s.size(); i++) begin
         send_byte(s[i], 3);
         if (i == 5) begin
            reload = 1'b1;
            tick();
            reload = 1'b0;
         end
      end
      n_cmp += 2;
      if (done !== 1'b1)      begin n_err++; $display("FAIL gaps_done got %b required 1", done); end
      if (core_hold !== 1'b0) begin n_err++; $display("FAIL gaps_hold got %b required 0", core_hold); end
      repeat (2) tick();
      n_cmp++;
      if (wr_cnt - w0 != 1)   begin n_err++; $display("FAIL gaps_writes got %0d required 1", wr_cnt - w0); end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      logic [7:0] s[$];
      int w0;
      s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h45};
      do_reset();
      w0 = wr_cnt;
      exp_q.push_back({BASE, 32'h1122_3344});
      exp_q.push_back({BASE + 32'd4, 32'hAABB_CCDD});
      foreach (s[i]) send_byte(s[i], 0);
      n_cmp += 4;
      if (error !== 1'b1)     begin n_err++; $display("FAIL badcs_error got %b required 1", error); end
      if (core_hold !== 1'b1) begin n_err++; $display("FAIL badcs_hold got %b required 1", core_hold); end
      if (rx_ready !== 1'b0)  begin n_err++; $display("FAIL badcs_rx_ready got %b required 0", rx_ready); end
      if (done !== 1'b0)      begin n_err++; $display("FAIL badcs_done got %b required 0", done); end
      repeat (2) tick();
      n_cmp++;
      if (wr_cnt - w0 != 2)   begin n_err++; $display("FAIL badcs_writes got %0d required 2", wr_cnt - w0); end
   endtask
`endif

   task automatic test_oversize();
      logic [7:0] s[$];
      int w0;
      s = '{8'h01, 8'h01, 8'h00, 8'h00};
      do_reset();
      w0 = wr_cnt;
      foreach (s[i]) send_byte(s[i], 0);
      n_cmp += 4;
      if (error !== 1'b1)     begin n_err++; $display("FAIL over_error got %b required 1", error); end
      if (rx_ready !== 1'b0)  begin n_err++; $display("FAIL over_rx_ready got %b required 0", rx_ready); end
      if (core_hold !== 1'b1) begin n_err++; $display("FAIL over_hold got %b required 1", core_hold); end
      if (done !== 1'b0)      begin n_err++; $display("FAIL over_done got %b required 0", done); end
      reload = 1'b1;
      tick();
      reload = 1'b0;
      repeat (2) tick();
      n_cmp += 2;
      if (error !== 1'b1)     begin n_err++; $display("FAIL err_sticky got %b required 1", error); end
      if (wr_cnt != w0)       begin n_err++; $display("FAIL over_writes got %0d required 0", wr_cnt - w0); end
   endtask

   task automatic test_empty();
      logic [7:0] s[$];
      int w0;
      s = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      s.push_back(8'h00);
`endif
      do_reset();
      w0 = wr_cnt;
      foreach (s[i]) send_byte(s[i], 0);
      n_cmp += 3;
      if (done !== 1'b1)      begin n_err++; $display("FAIL empty_done got %b required 1", done); end
      if (core_hold !== 1'b0) begin n_err++; $display("FAIL empty_hold got %b required 0", core_hold); end
      if (error !== 1'b0)     begin n_err++; $display("FAIL empty_error got %b required 0", error); end
      repeat (2) tick();
      n_cmp++;
      if (wr_cnt != w0)       begin n_err++; $display("FAIL empty_writes got %0d required 0", wr_cnt - w0); end
   endtask

   task automatic test_reset_mid_data();
      logic [7:0] s[$];
      int w0;
      s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
`ifdef LOADER_CHECKSUM_EN
      s.push_back(8'h44);
`endif
      do_reset();
      w0 = wr_cnt;
      for (int i = 0; i < 6; i++) send_byte(s[i], 0);
      do_reset();
      n_cmp += 4;
      if (rx_ready !== 1'b1)  begin n_err++; $display("FAIL mid_rx_ready got %b required 1", rx_ready); end
      if (core_hold !== 1'b1) begin n_err++; $display("FAIL mid_hold got %b required 1", core_hold); end
      if (imem_we !== 1'b0)   begin n_err++; $display("FAIL mid_we got %b required 0", imem_we); end
      if (done !== 1'b0)      begin n_err++; $display("FAIL mid_done got %b required 0", done); end
      repeat (3) tick();
      n_cmp++;
      if (wr_cnt != w0)       begin n_err++; $display("FAIL mid_writes got %0d required 0", wr_cnt - w0); end
      exp_q.push_back({BASE, 32'h1122_3344});
      exp_q.push_back({BASE + 32'd4, 32'hAABB_CCDD});
      foreach (s[i]) send_byte(s[i], 0);
      repeat (2) tick();
      n_cmp += 2;
      if (done !== 1'b1)      begin n_err++; $display("FAIL resend_done got %b required 1", done); end
      if (wr_cnt - w0 != 2)   begin n_err++; $display("FAIL resend_writes got %0d required 2", wr_cnt - w0); end
   endtask

   task automatic test_full_depth();
      logic [7:0]  iv;
      logic [31:0] w;
      logic [7:0]  cs;
      int          w0;
      do_reset();
      w0 = wr_cnt;
      cs = 8'h00;
      send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      for (int i = 0; i < DEPTH; i++) begin
         iv = 8'(i);
         w  = {iv + 8'd1, iv ^ 8'h5A, ~iv, iv};
         exp_q.push_back({BASE + 32'(i) * 32'd4, w});
         for (int k = 0; k < 4; k++) begin
            cs = cs ^ w[8*k +: 8];
            send_byte(w[8*k +: 8], 0);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(cs, 0);
`endif
      n_cmp += 2;
      if (done !== 1'b1)      begin n_err++; $display("FAIL full_done got %b required 1", done); end
      if (error !== 1'b0)     begin n_err++; $display("FAIL full_error got %b required 0", error); end
      repeat (2) tick();
      n_cmp++;
      if (wr_cnt - w0 != DEPTH) begin n_err++; $display("FAIL full_writes got %0d required %0d", wr_cnt - w0, DEPTH); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      wr_cnt = 0;
      fork
         monitor_writes();
      join_none
      test_reset();
      test_normal_load();
      test_reload_gaps();
`ifdef LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      test_oversize();
      test_empty();
      test_reset_mid_data();
      test_full_depth();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

- Writer-side counterpart to the core's instruction fetch path.
- Receives a program image as a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them into instruction memory at PC-compatible byte addresses.
- Holds the processor core in reset until the image is complete and, when enabled, checksum-verified.
- Sits between the host byte link and the instruction memory write port, alongside the processor core.

## Interface

**Parameters**
- `DEPTH_WORDS`, 256: instruction memory capacity in 32-bit words.
- `BASE_ADDR`, 32'h0: byte address of the first word written.

**Ports**
- `clk`, input, 1: sole clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `rx_data`, input, 8: incoming image byte.
- `rx_valid`, input, 1: `rx_data` is valid.
- `rx_ready`, output, 1: loader accepts a byte this cycle.
- `reload`, input, 1: single-cycle request to load a new image; honoured only in DONE.
- `imem_we`, output, 1: instruction memory write strobe, one cycle per word.
- `imem_addr`, output, 32: byte address, `BASE_ADDR + 4*index`.
- `imem_wdata`, output, 32: assembled instruction word.
- `core_hold`, output, 1: high keeps the processor core in reset.
- `done`, output, 1: image loaded and accepted.
- `error`, output, 1: image rejected.

## Operation

- **Image format**, all fields little-endian:
  - 4-byte word count N.
  - N × 4 instruction bytes.
  - With checksum enabled: 1 checksum byte, the XOR of all instruction bytes. Length bytes are excluded.
- **Byte transfer:** a byte is accepted on an edge where `rx_valid && rx_ready`. A 2-bit byte index wraps 3→0 on every 4th byte.
- **States:** LEN, DATA, CSUM, DONE, ERR.
  - LEN: collect 4 bytes into N.
    - On the 4th byte, if N > `DEPTH_WORDS`, go to ERR.
    - Else if N = 0, go to CSUM (or to DONE when checksum is compiled out).
    - Else go to DATA.
  - DATA: collect words. On the 4th byte of word i:
    - Next cycle: `imem_we`=1, `imem_addr`=`BASE_ADDR+4*i`, `imem_wdata`={b3,b2,b1,b0}.
    - After word N-1, go to CSUM (or to DONE when checksum is compiled out).
  - CSUM: accept one byte.
    - If it equals the running XOR, go to DONE.
    - Otherwise go to ERR.
  - DONE: `done`=1, `core_hold`=0, `rx_ready`=0. On `reload`=1, go to LEN with counters and checksum cleared.
  - ERR: `error`=1, `core_hold`=1, `rx_ready`=0. Leaves only via `reset`.
- **`rx_ready`:** 1 in LEN/DATA/CSUM, 0 in DONE/ERR. It is never dropped for a memory write, because the write register is separate from the assembly buffer.
- **Word index width:** `$clog2(DEPTH_WORDS)+1` bits. N is compared against `DEPTH_WORDS` at full 32-bit width.
- **`reload` outside DONE:** ignored.
- **Reset values:**
  - State LEN.
  - `rx_ready`=1 (in the first cycle after reset release).
  - `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0.
  - `core_hold`=1, `done`=0, `error`=0.
  - All counters and the checksum cleared.

## Timing

- Write latency: `imem_we` is asserted exactly 1 cycle after the edge that accepts the word's 4th byte.
- Maximum throughput: 1 byte per cycle, 1 write every 4 cycles.
- State change: `done`/`error` go high, and `core_hold` falls for DONE, 1 cycle after the edge accepting the final byte.
  - The final byte is the checksum byte, or the last data byte when checksum is compiled out.
  - For the last word, the final write strobe and the transition to DONE fall in the same cycle.
- Reload: `core_hold` rises and `done` falls 1 cycle after the edge that samples `reload`.
- Reset mid-image:
  - Partial word is discarded.
  - Any pending `imem_we` is cleared.
  - Reload restarts from LEN.
- `rx_valid` gaps: no state change; the byte index holds.

## Configuration

- `LOADER_CHECKSUM_EN`
  - Defined: CSUM state and XOR accumulator are present. A bad checksum leads to ERR.
  - Undefined: CSUM and the accumulator are removed. After the last word (or N=0) the loader goes directly to DONE. ERR is reachable only through oversize N.

## Structure

- **Package `loader_pkg`:**
  - State enum.
  - `LEN_BYTES`=4, `WORD_BYTES`=4.
  - Little-endian byte-lane constants.
- **Sub-module `word_assembler`:**
  - 4-byte shift/lane register with 2-bit index.
  - Emits the assembled word plus a `word_valid` pulse.
  - Used for both the length field and instruction words.
- **Top level:** owns the FSM, word counter, checksum and write register.

## Test plan

- **Normal load:** DEPTH 256, stream `02 00 00 00 44 33 22 11 DD CC BB AA 44`. Expect writes addr 0/0x11223344 and addr 4/0xAABBCCDD, then `done`=1 and `core_hold`=0.
- **Bad checksum:** same stream with final byte 0x45. Expect both writes, then `error`=1, `core_hold`=1, `rx_ready`=0.
- **Oversize length:** length `01 01 00 00` (257). Expect ERR one cycle after the 4th byte and no `imem_we`.
- **Empty image:** `00 00 00 00 00`. Expect `done`=1 with zero writes. With `LOADER_CHECKSUM_EN` undefined, `done` follows the 4th length byte.
- **Reset mid-DATA:** after 6 bytes, drive `reset` low for 1 cycle. Expect LEN, no write, `core_hold`=1. A full resend then loads correctly.
- **Reload with gaps:** in DONE, pulse `reload`. Expect `core_hold`=1 the next cycle. A new one-word image sent with random `rx_valid` gaps overwrites addr 0.
